regdst_pipe: RTL and testbench

//  Parametrised successor to the single-cycle write-register destination mux.

---
 rtl/regdst_pipe.sv | 130 +++++++++++++
 tb/tb_regdst_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regdst_pipe.sv
// Write-register destination select plus a short pipeline of in-flight
// destinations tagged with a Tnew countdown. The decode-stage sources are
// compared against every tracked stage to produce a stall request and
// one-hot forwarding selects.
module regdst_pipe #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int TNEW_W   = 2,
  parameter int LINK_REG = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          rt,
  input  logic [ADDR_W-1:0]          rd,
  input  logic [1:0]                 regdst,
  input  logic                       reg_we,
  input  logic [TNEW_W-1:0]          tnew_in,
  input  logic [ADDR_W-1:0]          src1,
  input  logic [ADDR_W-1:0]          src2,
  input  logic [TNEW_W-1:0]          tuse1,
  input  logic [TNEW_W-1:0]          tuse2,
  input  logic                       stall,
  input  logic                       flush,
  output logic [STAGES*ADDR_W-1:0]   dst_bus,
  output logic [STAGES*TNEW_W-1:0]   tnew_bus,
  output logic                       stall_req,
  output logic [STAGES-1:0]          fwd1,
  output logic [STAGES-1:0]          fwd2
);

  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [ADDR_W-1:0] sel;
  logic [ADDR_W-1:0] dest;

  logic [ADDR_W-1:0] addr_q [STAGES];
  logic [ADDR_W-1:0] addr_d [STAGES];
  logic [TNEW_W-1:0] tnew_q [STAGES];
  logic [TNEW_W-1:0] tnew_d [STAGES];

  logic [ADDR_W-1:0] src_a  [2];
  logic [TNEW_W-1:0] tuse_a [2];
  logic [STAGES-1:0] fwd_a  [2];
  logic [1:0]        stall_a;
  logic              found;

  // Destination select; address 0 doubles as the "no write" marker.
  always_comb begin
    sel = '0;
    case (regdst)
      2'b00:   sel = rt;
      2'b01:   sel = rd;
      2'b10:   sel = LINK_ADDR;
      default: sel = '0;
    endcase
    dest = (reg_we && (regdst != 2'b11)) ? sel : '0;
  end

  // Next-state for the stage chain: stage0 takes a bubble on stall/flush,
  // older stages always advance with a Tnew decrement that saturates at 0.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      addr_d[k] = '0;
      tnew_d[k] = '0;
    end
    if (!(flush || stall)) begin
      addr_d[0] = dest;
      tnew_d[0] = tnew_in;
    end
    for (int k = 1; k < STAGES; k++) begin
      addr_d[k] = addr_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : (tnew_q[k-1] - TNEW_W'(1));
    end
  end

  // Stage registers; reset clears every stage immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        addr_q[k] <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        addr_q[k] <= addr_d[k];
        tnew_q[k] <= tnew_d[k];
      end
    end
  end

  // Flatten the stage registers onto the output buses.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_pack
      assign dst_bus[gi*ADDR_W +: ADDR_W]  = addr_q[gi];
      assign tnew_bus[gi*TNEW_W +: TNEW_W] = tnew_q[gi];
    end
  endgenerate

  assign src_a[0]  = src1;
  assign src_a[1]  = src2;
  assign tuse_a[0] = tuse1;
  assign tuse_a[1] = tuse2;

  // Hazard detection: only the youngest matching stage counts. A result
  // not ready in time stalls; a ready one forwards; one that will be
  // ready before use needs neither.
  always_comb begin
    stall_a = '0;
    found   = 1'b0;
    for (int j = 0; j < 2; j++) begin
      fwd_a[j] = '0;
      found    = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        if (!found && (src_a[j] != '0) && (addr_q[k] == src_a[j])) begin
          found = 1'b1;
          if (tnew_q[k] > tuse_a[j]) begin
            stall_a[j] = 1'b1;
          end else if (tnew_q[k] == '0) begin
            fwd_a[j][k] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_req = |stall_a;
  assign fwd1      = fwd_a[0];
  assign fwd2      = fwd_a[1];

endmodule

// File: tb/tb_regdst_pipe.sv
// Directed bench for regdst_pipe: reset, destination select, shift/Tnew
// countdown, stall handling, youngest-match priority and flush+stall.
module tb_regdst_pipe;
  localparam int ADDR_W = 5;
  localparam int STAGES = 3;
  localparam int TNEW_W = 2;

  logic                     clk;
  logic                     reset;
  logic [ADDR_W-1:0]        rt, rd, src1, src2;
  logic [1:0]               regdst;
  logic                     reg_we, stall, flush;
  logic [TNEW_W-1:0]        tnew_in, tuse1, tuse2;
  logic [STAGES*ADDR_W-1:0] dst_bus;
  logic [STAGES*TNEW_W-1:0] tnew_bus;
  logic                     stall_req;
  logic [STAGES-1:0]        fwd1, fwd2;

  int errors = 0;
  int checks = 0;

  regdst_pipe #(.ADDR_W(ADDR_W), .STAGES(STAGES), .TNEW_W(TNEW_W), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .rt(rt), .rd(rd), .regdst(regdst), .reg_we(reg_we),
    .tnew_in(tnew_in), .src1(src1), .src2(src2), .tuse1(tuse1), .tuse2(tuse2),
    .stall(stall), .flush(flush), .dst_bus(dst_bus), .tnew_bus(tnew_bus),
    .stall_req(stall_req), .fwd1(fwd1), .fwd2(fwd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ADDR_W-1:0] st_addr(input int k);
    return dst_bus[k*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [TNEW_W-1:0] st_tnew(input int k);
    return tnew_bus[k*TNEW_W +: TNEW_W];
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode slot carries a non-writing instruction.
  task automatic drive_nop();
    reg_we = 1'b0; regdst = 2'b11; tnew_in = '0; rt = '0; rd = '0;
  endtask

  task automatic drain();
    drive_nop();
    stall = 1'b0; flush = 1'b0;
    src1 = '0; src2 = '0; tuse1 = '0; tuse2 = '0;
    repeat (STAGES + 1) tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dst_bus !== '0 || tnew_bus !== '0) begin
      errors++; $display("FAIL reset_held: dst=%h tnew=%h required 0/0", dst_bus, tnew_bus);
    end
    checks++;
    if (stall_req !== 1'b0 || fwd1 !== '0 || fwd2 !== '0) begin
      errors++; $display("FAIL reset_hazard: stall=%b fwd1=%b fwd2=%b required 0", stall_req, fwd1, fwd2);
    end
    // release, then issue rd=5 for three clocks
    @(negedge clk); reset = 1'b1;
    regdst = 2'b01; rd = 5'd5; reg_we = 1'b1; tnew_in = 2'd1;
    repeat (3) tick();
    checks++;
    if (st_addr(0) !== 5'd5 || st_addr(2) !== 5'd5) begin
      errors++; $display("FAIL reset_prefill: s0=%0d s2=%0d required 5/5", st_addr(0), st_addr(2));
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dst_bus !== '0 || tnew_bus !== '0) begin
      errors++; $display("FAIL reset_async: dst=%h tnew=%h required 0/0", dst_bus, tnew_bus);
    end
    $display("reset: async clear dst=%h tnew=%h", dst_bus, tnew_bus);
    @(negedge clk); reset = 1'b1;
    drain();
  endtask

  task automatic test_select();
    logic [1:0]        rd_sel [5];
    logic              we_v   [5];
    logic [ADDR_W-1:0] exp_a  [5];
    rd_sel = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    we_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_a  = '{5'd3, 5'd7, 5'd31, 5'd0, 5'd0};
    for (int i = 0; i < 5; i++) begin
      rt = 5'd3; rd = 5'd7; regdst = rd_sel[i]; reg_we = we_v[i]; tnew_in = 2'd1;
      tick();
      checks++;
      if (st_addr(0) !== exp_a[i]) begin
        errors++; $display("FAIL select_%0d: stage0 addr=%0d required %0d", i, st_addr(0), exp_a[i]);
      end
      $display("select: regdst=%b we=%b -> stage0 addr=%0d", rd_sel[i], we_v[i], st_addr(0));
    end
    drain();
  endtask

  task automatic test_shift();
    logic [ADDR_W-1:0] ea [4];
    logic [TNEW_W-1:0] et [4];
    ea = '{5'd9, 5'd9, 5'd9, 5'd0};
    et = '{2'd2, 2'd1, 2'd0, 2'd0};
    regdst = 2'b01; rd = 5'd9; reg_we = 1'b1; tnew_in = 2'd2;
    tick();
    drive_nop();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st_addr(i) !== ea[i] || st_tnew(i) !== et[i] || st_addr(0) !== (i == 0 ? 5'd9 : 5'd0)) begin
        errors++; $display("FAIL shift_s%0d: {%0d,%0d} s0=%0d required {%0d,%0d}",
                           i, st_addr(i), st_tnew(i), st_addr(0), ea[i], et[i]);
      end
      $display("shift: stage%0d {%0d,%0d}", i, st_addr(i), st_tnew(i));
      tick();
    end
    checks++;
    if (dst_bus !== '0) begin
      errors++; $display("FAIL shift_drop: dst=%h required 0", dst_bus);
    end
    drain();
  endtask

  task automatic test_stall();
    regdst = 2'b00; rt = 5'd4; reg_we = 1'b1; tnew_in = 2'd2;
    tick();
    // next decode instr reads r4
    regdst = 2'b01; rd = 5'd8; reg_we = 1'b1; tnew_in = 2'd1;
    src1 = 5'd4; tuse1 = 2'd2; #1;
    checks++;
    if (stall_req !== 1'b0 || fwd1 !== 3'b000) begin
      errors++; $display("FAIL stall_tuse2: stall=%b fwd1=%b required 0/000", stall_req, fwd1);
    end
    tuse1 = 2'd0; #1;
    checks++;
    if (stall_req !== 1'b1 || fwd1 !== 3'b000) begin
      errors++; $display("FAIL stall_e: stall=%b fwd1=%b required 1/000", stall_req, fwd1);
    end
    $display("stall: stage0 {%0d,%0d} src1=4 tuse1=0 stall_req=%b", st_addr(0), st_tnew(0), stall_req);
    stall = 1'b1;
    tick();
    checks++;
    if (st_addr(0) !== 5'd0 || st_addr(1) !== 5'd4 || st_tnew(1) !== 2'd1 || stall_req !== 1'b1) begin
      errors++; $display("FAIL stall_m: s0=%0d s1={%0d,%0d} stall=%b required 0,{4,1},1",
                         st_addr(0), st_addr(1), st_tnew(1), stall_req);
    end
    tick();
    checks++;
    if (st_addr(2) !== 5'd4 || st_tnew(2) !== 2'd0 || stall_req !== 1'b0 || fwd1 !== 3'b100) begin
      errors++; $display("FAIL stall_w: s2={%0d,%0d} stall=%b fwd1=%b required {4,0},0,100",
                         st_addr(2), st_tnew(2), stall_req, fwd1);
    end
    $display("stall: stage2 {%0d,%0d} fwd1=%b stall_req=%b", st_addr(2), st_tnew(2), fwd1, stall_req);
    stall = 1'b0;
    tick();
    checks++;
    if (st_addr(0) !== 5'd8 || st_tnew(0) !== 2'd1 || fwd1 !== 3'b000) begin
      errors++; $display("FAIL stall_release: s0={%0d,%0d} fwd1=%b required {8,1},000",
                         st_addr(0), st_tnew(0), fwd1);
    end
    drain();
  endtask

  task automatic test_youngest();
    regdst = 2'b01; rd = 5'd6; reg_we = 1'b1; tnew_in = 2'd0;
    tick(); tick();
    drive_nop();
    src2 = 5'd6; tuse2 = 2'd0; #1;
    checks++;
    if (fwd2 !== 3'b001 || stall_req !== 1'b0) begin
      errors++; $display("FAIL youngest_fwd: fwd2=%b stall=%b required 001/0", fwd2, stall_req);
    end
    $display("youngest: stage0/1 {6,0} src2=6 fwd2=%b", fwd2);
    drain();
    // younger not-ready r6 ahead of older ready r6: must stall, not forward
    regdst = 2'b01; rd = 5'd6; reg_we = 1'b1; tnew_in = 2'd0;
    tick();
    tnew_in = 2'd2;
    tick();
    drive_nop();
    src2 = 5'd6; tuse2 = 2'd0; #1;
    checks++;
    if (stall_req !== 1'b1 || fwd2 !== 3'b000) begin
      errors++; $display("FAIL youngest_stall: stall=%b fwd2=%b required 1/000", stall_req, fwd2);
    end
    drain();
    // bubbles everywhere and zero sources: nothing may match
    src1 = '0; src2 = '0; #1;
    checks++;
    if (fwd1 !== '0 || fwd2 !== '0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL zero_src: fwd1=%b fwd2=%b stall=%b required 0", fwd1, fwd2, stall_req);
    end
    $display("youngest: src=0 fwd1=%b fwd2=%b stall=%b", fwd1, fwd2, stall_req);
  endtask

  task automatic test_flush_stall();
    regdst = 2'b01; rd = 5'd12; reg_we = 1'b1; tnew_in = 2'd1;
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++;
    if (st_addr(0) !== 5'd0 || st_tnew(0) !== 2'd0) begin
      errors++; $display("FAIL flush_stall: s0={%0d,%0d} required {0,0}", st_addr(0), st_tnew(0));
    end
    stall = 1'b0;
    tick();
    checks++;
    if (st_addr(0) !== 5'd0) begin
      errors++; $display("FAIL flush_only: s0=%0d required 0", st_addr(0));
    end
    flush = 1'b0;
    tick();
    checks++;
    if (st_addr(0) !== 5'd12 || st_tnew(0) !== 2'd1) begin
      errors++; $display("FAIL flush_resume: s0={%0d,%0d} required {12,1}", st_addr(0), st_tnew(0));
    end
    $display("flush: resumed stage0 {%0d,%0d}", st_addr(0), st_tnew(0));
    drain();
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0; flush = 1'b0;
    src1 = '0; src2 = '0; tuse1 = '0; tuse2 = '0;
    drive_nop();
    test_reset();
    test_select();
    test_shift();
    test_stall();
    test_youngest();
    test_flush_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
